// File: rtl/dec_ch_sched_pkg.sv
// dec_sched_pkg: shared types and constants for the decimator channel scheduler.
//   CH_W     - width of the channel tag presented with each granted word
//   SAMPLE_W - width of one I or Q sample
//   GAP_W    - width of the guard-gap down-counter (GAP_CYC up to 15)
//   state_t  - scheduler FSM states
//   sample_t - one I/Q sample pair, I in the upper half
package dec_sched_pkg;

  localparam int CH_W     = 2;
  localparam int SAMPLE_W = 16;
  localparam int GAP_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } sample_t;

endpackage

// File: rtl/dec_ch_sched_fifo.sv
// dec_ch_fifo: 2-entry synchronous holding FIFO for one scheduler channel.
//   clk   - clock
//   rst   - synchronous active-high reset
//   flush - empties the FIFO on the next edge (channel disabled)
//   push  - write wdata; ignored when full unless pop is also asserted
//   pop   - drop the head entry; caller only pops a non-empty FIFO
//   wdata - entry to write
//   head  - current head entry
//   full  - two entries held
//   empty - no entries held
module dec_ch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_r [2];
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         wr_s;
  logic         wr_idx_s;

  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign head  = mem_r[rd_ptr_r];

  // A push on a full FIFO is accepted only when the head leaves in the same cycle.
  assign wr_s = push & (~full | pop);
  // Free slot follows the head; when full this is the slot being popped.
  assign wr_idx_s = rd_ptr_r ^ count_r[0];

  // Storage, read pointer and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (wr_s) begin
        mem_r[wr_idx_s] <= wdata;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({wr_s, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dec_ch_sched.sv
// dec_ch_sched: round-robin scheduler sharing one decimator between NUM_CH
// I/Q channels, each buffered in a 2-entry FIFO, with a guard gap after
// every accepted word.
// Optional build macro: DEC_SCHED_LOOP_EN adds loop_sel/loop_data, which
// replace channel 0's sample source when loop_sel=1.
// Ports:
//   clk_200m  - system clock
//   cfg_rst   - synchronous active-high reset
//   ch_en     - per-channel enable; low flushes and excludes the channel
//   ch_valid  - per-channel one-cycle sample strobe
//   ch_i/ch_q - packed samples, channel n at [n*DW +: DW]
//   dec_ready - decimator accepts the presented word
//   dec_valid/dec_i/dec_q/dec_ch - word presented to the decimator
//   ovf_clr   - clears all overflow flags (a new overflow wins)
//   ovf_flag  - sticky per-channel overflow
//   loop_sel/loop_data - (DEC_SCHED_LOOP_EN only) channel 0 source override
module dec_ch_sched
  import dec_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DW      = SAMPLE_W,
  parameter int GAP_CYC = 4
) (
  input  logic                 clk_200m,
  input  logic                 cfg_rst,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH*DW-1:0] ch_i,
  input  logic [NUM_CH*DW-1:0] ch_q,
  input  logic                 dec_ready,
  output logic                 dec_valid,
  output logic [DW-1:0]        dec_i,
  output logic [DW-1:0]        dec_q,
  output logic [CH_W-1:0]      dec_ch,
  input  logic                 ovf_clr,
  output logic [NUM_CH-1:0]    ovf_flag
`ifdef DEC_SCHED_LOOP_EN
  ,
  input  logic                 loop_sel,
  input  logic [31:0]          loop_data
`endif
);

  sample_t             wdata_s [NUM_CH];
  sample_t             head_s  [NUM_CH];
  logic [NUM_CH-1:0]   full_s;
  logic [NUM_CH-1:0]   empty_s;
  logic [NUM_CH-1:0]   push_s;
  logic [NUM_CH-1:0]   pop_s;
  logic [NUM_CH-1:0]   ovf_set_s;

  state_t              state_r, state_nxt;
  logic                dec_valid_r, valid_nxt;
  sample_t             out_r, out_nxt;
  logic [CH_W-1:0]     ch_r, ch_nxt;
  logic [CH_W-1:0]     ptr_r, ptr_nxt;
  logic [GAP_W-1:0]    gap_r, gap_nxt;
  logic [NUM_CH-1:0]   ovf_r;

  logic                grant_vld_s;
  logic [CH_W-1:0]     grant_s;
  sample_t             grant_data_s;
  int                  arb_idx_s;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    if (n == 0) begin : g_slot0
`ifdef DEC_SCHED_LOOP_EN
      assign wdata_s[n] = loop_sel ? sample_t'(loop_data)
                                   : sample_t'({ch_i[n*DW +: DW], ch_q[n*DW +: DW]});
`else
      assign wdata_s[n] = sample_t'({ch_i[n*DW +: DW], ch_q[n*DW +: DW]});
`endif
    end else begin : g_slot
      assign wdata_s[n] = sample_t'({ch_i[n*DW +: DW], ch_q[n*DW +: DW]});
    end

    assign push_s[n]    = ch_valid[n] & ch_en[n];
    // Overflow only when the sample really is lost: full and no simultaneous pop.
    assign ovf_set_s[n] = push_s[n] & full_s[n] & ~pop_s[n];

    dec_ch_fifo #(.W(2*DW)) u_fifo (
      .clk   (clk_200m),
      .rst   (cfg_rst),
      .flush (~ch_en[n]),
      .push  (push_s[n]),
      .pop   (pop_s[n]),
      .wdata (wdata_s[n]),
      .head  (head_s[n]),
      .full  (full_s[n]),
      .empty (empty_s[n])
    );
  end

  // Round-robin pick: first enabled non-empty channel after the last granted one.
  always_comb begin
    grant_vld_s  = 1'b0;
    grant_s      = '0;
    grant_data_s = '0;
    arb_idx_s    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      arb_idx_s = (int'(ptr_r) + k) % NUM_CH;
      if (!grant_vld_s && ch_en[arb_idx_s] && !empty_s[arb_idx_s]) begin
        grant_vld_s  = 1'b1;
        grant_s      = CH_W'(arb_idx_s);
        grant_data_s = head_s[arb_idx_s];
      end else begin
        grant_vld_s  = grant_vld_s;
      end
    end
  end

  // FSM next state plus next values of the output register and pointers.
  always_comb begin
    state_nxt = state_r;
    valid_nxt = dec_valid_r;
    out_nxt   = out_r;
    ch_nxt    = ch_r;
    ptr_nxt   = ptr_r;
    gap_nxt   = gap_r;
    pop_s     = '0;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) begin
          pop_s     = NUM_CH'(1) << grant_s;
          out_nxt   = grant_data_s;
          ch_nxt    = grant_s;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (dec_ready) begin
          valid_nxt = 1'b0;
          ptr_nxt   = ch_r;
          if (GAP_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = GAP_W'(GAP_CYC - 1);
          end
        end else begin
          state_nxt = HOLD;
        end
      end
      GAP: begin
        if (gap_r == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt   = gap_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, presented word and round-robin pointer.
  always_ff @(posedge clk_200m) begin
    if (cfg_rst) begin
      state_r     <= IDLE;
      dec_valid_r <= 1'b0;
      out_r       <= '0;
      ch_r        <= '0;
      ptr_r       <= '0;
      gap_r       <= '0;
    end else begin
      state_r     <= state_nxt;
      dec_valid_r <= valid_nxt;
      out_r       <= out_nxt;
      ch_r        <= ch_nxt;
      ptr_r       <= ptr_nxt;
      gap_r       <= gap_nxt;
    end
  end

  // Sticky overflow flags; a new overflow outranks a clear in the same cycle.
  always_ff @(posedge clk_200m) begin
    if (cfg_rst) begin
      ovf_r <= '0;
    end else begin
      ovf_r <= (ovf_r & ~{NUM_CH{ovf_clr}}) | ovf_set_s;
    end
  end

  assign dec_valid = dec_valid_r;
  assign dec_i     = out_r.i;
  assign dec_q     = out_r.q;
  assign dec_ch    = ch_r;
  assign ovf_flag  = ovf_r;

endmodule

// File: tb/tb_dec_ch_sched.sv
// Testbench for dec_ch_sched: two instances (guard gap 4 and guard gap 0)
// share one stimulus stream; each is compared every cycle with a
// queue-based reference model of the scheduling rules.
module tb_dec_ch_sched;

  localparam int N     = 4;
  localparam int GAP_A = 4;
  localparam int GAP_B = 0;

  logic        clk_200m = 1'b0;
  logic        cfg_rst;
  logic [3:0]  ch_en, ch_valid;
  logic [63:0] ch_i, ch_q;
  logic        dec_ready, ovf_clr;
  logic        va, vb;
  logic [15:0] ia, qa, ib, qb;
  logic [1:0]  cha, chb;
  logic [3:0]  ova, ovb;
`ifdef DEC_SCHED_LOOP_EN
  logic        loop_sel;
  logic [31:0] loop_data;
`endif

  always #5 clk_200m = ~clk_200m;

  dec_ch_sched #(.NUM_CH(N), .DW(16), .GAP_CYC(GAP_A)) u_dut_a (
    .clk_200m(clk_200m), .cfg_rst(cfg_rst), .ch_en(ch_en), .ch_valid(ch_valid),
    .ch_i(ch_i), .ch_q(ch_q), .dec_ready(dec_ready), .dec_valid(va),
    .dec_i(ia), .dec_q(qa), .dec_ch(cha), .ovf_clr(ovf_clr), .ovf_flag(ova)
`ifdef DEC_SCHED_LOOP_EN
    , .loop_sel(loop_sel), .loop_data(loop_data)
`endif
  );

  dec_ch_sched #(.NUM_CH(N), .DW(16), .GAP_CYC(GAP_B)) u_dut_b (
    .clk_200m(clk_200m), .cfg_rst(cfg_rst), .ch_en(ch_en), .ch_valid(ch_valid),
    .ch_i(ch_i), .ch_q(ch_q), .dec_ready(dec_ready), .dec_valid(vb),
    .dec_i(ib), .dec_q(qb), .dec_ch(chb), .ovf_clr(ovf_clr), .ovf_flag(ovb)
`ifdef DEC_SCHED_LOOP_EN
    , .loop_sel(loop_sel), .loop_data(loop_data)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int          m_pres [2];
  logic [31:0] m_word [2];
  int          m_ch   [2];
  int          m_last [2];
  int          m_wait [2];
  logic [3:0]  m_ovf  [2];
  logic [31:0] mq [8][$];

  // Phase trackers for rate and rotation checks.
  bit track = 1'b0;
  bit va_q = 1'b0, vb_q = 1'b0;
  int rise_a = -1, rise_b = -1, prev_b = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sample_word(input int c);
`ifdef DEC_SCHED_LOOP_EN
    if (c == 0 && loop_sel) return loop_data;
`endif
    return {ch_i[c*16 +: 16], ch_q[c*16 +: 16]};
  endfunction

  task automatic model_reset(input int k);
    m_pres[k] = 0; m_word[k] = '0; m_ch[k] = 0;
    m_last[k] = 0; m_wait[k] = 0; m_ovf[k] = '0;
    for (int c = 0; c < N; c++) mq[k*4+c].delete();
  endtask

  // One clock edge of the scheduling rules, using the inputs seen at that edge.
  task automatic model_step(input int k, input int gap);
    int g;
    logic [3:0] setv;
    if (cfg_rst) begin
      model_reset(k);
      return;
    end
    g = -1;
    setv = '0;
    if (m_pres[k] == 0 && m_wait[k] == 0) begin
      for (int s = 1; s <= N; s++) begin
        int c;
        c = (m_last[k] + s) % N;
        if (g < 0 && ch_en[c] && mq[k*4+c].size() > 0) g = c;
      end
    end
    if (m_pres[k] != 0 && dec_ready) begin
      m_pres[k] = 0;
      m_last[k] = m_ch[k];
      m_wait[k] = gap;
    end else if (m_pres[k] == 0 && m_wait[k] > 0) begin
      m_wait[k]--;
    end
    if (g >= 0) begin
      m_pres[k] = 1;
      m_word[k] = mq[k*4+g].pop_front();
      m_ch[k]   = g;
    end
    for (int c = 0; c < N; c++) begin
      if (!ch_en[c]) mq[k*4+c].delete();
      else if (ch_valid[c]) begin
        if (mq[k*4+c].size() < 2) mq[k*4+c].push_back(sample_word(c));
        else setv[c] = 1'b1;
      end
    end
    m_ovf[k] = (m_ovf[k] & ~{4{ovf_clr}}) | setv;
  endtask

  task automatic check_all();
    chk("a_valid", 32'(va), 32'(m_pres[0]));
    chk("a_ovf", 32'(ova), 32'(m_ovf[0]));
    if (m_pres[0] != 0) begin
      chk("a_data", {ia, qa}, m_word[0]);
      chk("a_ch", 32'(cha), 32'(m_ch[0]));
    end
    chk("b_valid", 32'(vb), 32'(m_pres[1]));
    chk("b_ovf", 32'(ovb), 32'(m_ovf[1]));
    if (m_pres[1] != 0) begin
      chk("b_data", {ib, qb}, m_word[1]);
      chk("b_ch", 32'(chb), 32'(m_ch[1]));
    end
  endtask

  task automatic step();
    @(posedge clk_200m);
    model_step(0, GAP_A);
    model_step(1, GAP_B);
    #1;
    check_all();
    cyc++;
    if (track) begin
      if (va && !va_q) begin
        if (rise_a >= 0) chk("gap_a_spacing", 32'(cyc - rise_a), 32'(GAP_A + 2));
        rise_a = cyc;
      end
      if (vb && !vb_q) begin
        if (rise_b >= 0) begin
          chk("tput_b_spacing", 32'(cyc - rise_b), 32'd2);
          chk("rr_b_order", 32'(chb), 32'((prev_b + 1) % N));
        end
        prev_b = int'(chb);
        rise_b = cyc;
      end
    end
    va_q = va;
    vb_q = vb;
  endtask

  initial begin
    bit seen3;
    cfg_rst = 1'b1; ch_en = '0; ch_valid = '0; ch_i = '0; ch_q = '0;
    dec_ready = 1'b1; ovf_clr = 1'b0;
`ifdef DEC_SCHED_LOOP_EN
    loop_sel = 1'b0; loop_data = '0;
`endif
    step(); step();
    chk("rst_data", {ia, qa}, 32'h0);
    chk("rst_ch", 32'(cha), 32'h0);

    // Single push on ch2: visible two cycles after the strobe, for one cycle.
    cfg_rst = 1'b0; ch_en = 4'hF;
    ch_valid = 4'b0100; ch_i[32 +: 16] = 16'h1234; ch_q[32 +: 16] = 16'hABCD;
    step();
    chk("sp_not_yet", 32'(va), 32'd0);
    ch_valid = '0;
    step();
    chk("sp_valid", 32'(va), 32'd1);
    chk("sp_i", 32'(ia), 32'h1234);
    chk("sp_q", 32'(qa), 32'hABCD);
    chk("sp_ch", 32'(cha), 32'd2);
    step();
    chk("sp_one_cycle", 32'(va), 32'd0);

    // Continuous requests on all channels: rotation, throughput and gap spacing.
    cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
    track = 1'b1;
    repeat (60) begin
      ch_valid = 4'hF;
      ch_i = {$urandom, $urandom};
      ch_q = {$urandom, $urandom};
      step();
    end
    track = 1'b0;
    ch_valid = '0;

    // Backpressure: word from ch0 held while ch1 overflows.
    cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
    dec_ready = 1'b0;
    ch_valid = 4'b0001; ch_i[0 +: 16] = 16'h1111; ch_q[0 +: 16] = 16'h2222;
    step();
    ch_valid = '0;
    step();
    for (int t = 0; t < 10; t++) begin
      ch_valid = '0; ovf_clr = 1'b0;
      if (t < 4) begin
        ch_valid = 4'b0010;
        ch_i[16 +: 16] = 16'($urandom); ch_q[16 +: 16] = 16'($urandom);
      end
      if (t == 3 || t == 4) ovf_clr = 1'b1;
      step();
      chk("bp_valid", 32'(va), 32'd1);
      chk("bp_word", {ia, qa}, 32'h1111_2222);
      chk("bp_ch", 32'(cha), 32'd0);
      if (t == 2) chk("ovf1_set", 32'(ova[1]), 32'd1);
      if (t == 3) chk("ovf1_set_wins", 32'(ova[1]), 32'd1);
      if (t == 4) chk("ovf1_cleared", 32'(ova[1]), 32'd0);
    end
    ovf_clr = 1'b0; ch_valid = '0;

    // Disable ch3 while it holds two words: none of them is ever granted.
    ch_valid = 4'b1000; step(); step();
    ch_valid = '0; ch_en = 4'b0111; step();
    dec_ready = 1'b1;
    seen3 = 1'b0;
    repeat (30) begin
      step();
      if ((va && cha == 2'd3) || (vb && chb == 2'd3)) seen3 = 1'b1;
    end
    chk("no_ch3_after_disable", 32'(seen3), 32'd0);
    ch_en = 4'hF;

    // Randomised traffic.
    repeat (400) begin
      for (int c = 0; c < N; c++) ch_en[c] = ($urandom_range(0, 7) != 0);
      ch_valid  = 4'($urandom);
      ch_i      = {$urandom, $urandom};
      ch_q      = {$urandom, $urandom};
      dec_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      step();
    end
    ovf_clr = 1'b0; ch_valid = '0;

    // Reset while a word is held: everything returns to zero.
    cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
    ch_en = 4'hF; dec_ready = 1'b0;
    ch_valid = 4'b0100; step();
    ch_valid = 4'b0010; step(); step(); step();
    chk("pre_rst_hold", 32'(va), 32'd1);
    chk("pre_rst_ovf1", 32'(ova[1]), 32'd1);
    ch_valid = '0; cfg_rst = 1'b1;
    step();
    chk("rst_hold_valid", 32'(va), 32'd0);
    chk("rst_hold_data", {ia, qa}, 32'h0);
    chk("rst_hold_ch", 32'(cha), 32'd0);
    chk("rst_hold_ovf", 32'(ova), 32'd0);
    cfg_rst = 1'b0; dec_ready = 1'b1;
    step();

`ifdef DEC_SCHED_LOOP_EN
    // Loopback source on channel 0.
    loop_sel = 1'b1; loop_data = 32'h5555_AAAA;
    ch_i = {$urandom, $urandom}; ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    step();
    chk("loop_i", 32'(ia), 32'h5555);
    chk("loop_q", 32'(qa), 32'hAAAA);
    chk("loop_ch", 32'(cha), 32'd0);
    loop_sel = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
